// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file and its clear sweeper.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clrState_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sweeper: walks idx over every register while busy, then pulses done for one cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone,
  output logic [ADDR_W-1:0] idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  clrState_t state;

  // Outputs are registered alongside state so busy/done always match the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      clrBusy <= 1'b0;
      clrDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clrReq) begin
            state   <= SWEEP;
            idx     <= '0;
            clrBusy <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == LAST_IDX) begin
            state   <= DONE;
            clrBusy <= 1'b0;
            clrDone <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          clrDone <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          clrBusy <= 1'b0;
          clrDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Two-read/one-write register file with byte enables and a sweep clear.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] clrIdx;
  logic              wrAccept;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [DATA_W-1:0] mergeBytes(
    input logic [DATA_W-1:0] oldVal,
    input logic [DATA_W-1:0] newVal,
    input logic [BYTES-1:0]  be
  );
    logic [DATA_W-1:0] res;
    res = oldVal;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = isZeroReg(addr) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (wrAccept && (addr == wr_addr)) val = mergeBytes(regs[addr], wr_data, wr_be);
`endif
    return val;
  endfunction

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) uClearFsm (
    .clk     (clk),
    .rst     (rst),
    .clrReq  (clr_req),
    .clrBusy (clr_busy),
    .clrDone (clr_done),
    .idx     (clrIdx)
  );

  assign wr_ready = !clr_busy;
  // Writes to a hardwired zero register are dropped here, so it also never forwards.
  assign wrAccept = wr_en && wr_ready && !isZeroReg(wr_addr);

  // Sweep and write never overlap: writes are only accepted while the sweeper is not busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (clr_busy) regs[clrIdx] <= '0;
      if (wrAccept) regs[wr_addr] <= mergeBytes(regs[wr_addr], wr_data, wr_be);
    end
  end

  always_comb begin
    rd_data1 = readPort(rd_addr1);
    rd_data2 = readPort(rd_addr2);
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with a queue of expected read values.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_ready, wr_ready0;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] rd_data1, rd_data2, z0rd1, z0rd2;
  logic        clr_req = 1'b0;
  logic        clr_busy, clr_done, clr_busy0, clr_done0;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] model [32];

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_ready(wr_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_ready(wr_ready0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z0rd1), .rd_data2(z0rd2), .clr_req(clr_req),
    .clr_busy(clr_busy0), .clr_done(clr_done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkPop(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      exp = expQ.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Drives one write, predicts the ZERO_REG=1 result, then reads it back on port 1.
  task automatic doWrite(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    if (a != 5'd0) model[a] = merge(model[a], d, be);
    expQ.push_back(model[a]);
    tick();
    wr_en = 1'b0; wr_be = '0;
    rd_addr1 = a;
    #1;
    chkPop(tag, rd_data1);
  endtask

  initial begin
    int cnt;
    int donePulses;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    rd_addr1 = 5'd5; rd_addr2 = 5'd31;
    #1;
    chk("rst_rd1", rd_data1, 32'd0);
    chk("rst_rd2", rd_data2, 32'd0);
    #5 rst = 1'b0;
    tick();

    // Write r5: old value before the edge, new value after
    rd_addr1 = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
`ifdef REGFILE_BYPASS_EN
    expQ.push_back(32'hDEADBEEF);
`else
    expQ.push_back(32'h0);
`endif
    #1;
    chkPop("r5_pre", rd_data1);
    wr_en = 1'b0;
    model[5] = 32'hDEADBEEF;
    doWrite("r5_post", 5'd5, 32'hDEADBEEF, 4'hF);

    // Byte enables
    doWrite("r7_full", 5'd7, 32'h11223344, 4'hF);
    doWrite("r7_be5", 5'd7, 32'hAABBCCDD, 4'b0101);
    chk("r7_const", rd_data1, 32'h11BB33DD);
    doWrite("r7_be0", 5'd7, 32'hFFFFFFFF, 4'b0000);
    doWrite("r7_be8", 5'd7, 32'h99000000, 4'b1000);

    // Zero register on both configurations
    doWrite("r0_zr1", 5'd0, 32'hFFFFFFFF, 4'hF);
    chk("r0_zr0", z0rd1, 32'hFFFFFFFF);

    // Same-cycle read of a write target on port 2
    doWrite("r3_init", 5'd3, 32'h0000AAAA, 4'hF);
    rd_addr2 = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; wr_be = 4'hF;
`ifdef REGFILE_BYPASS_EN
    expQ.push_back(32'h12345678);
`else
    expQ.push_back(32'h0000AAAA);
`endif
    #1;
    chkPop("r3_same", rd_data2);
    wr_en = 1'b0;
    model[3] = 32'h12345678;
    doWrite("r3_post", 5'd3, 32'h12345678, 4'hF);

    // Fill r1..r31
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = {8'(i), 8'hA5, 8'(i), 8'h5A}; wr_be = 4'hF;
      model[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;

    // Write and clear request together: write lands, then sweep clears it
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; wr_be = 4'hF; clr_req = 1'b1;
    model[9] = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    rd_addr1 = 5'd9; rd_addr2 = 5'd20;
    #1;
    chk("wrclr_r9", rd_data1, 32'hCAFEF00D);
    chk("sweep_ready", {31'd0, wr_ready}, 32'd0);
    cnt = 0;
    donePulses = 0;
    while (clr_busy && cnt < 100) begin
      cnt++;
      if (cnt == 3) clr_req = 1'b1;
      if (cnt == 4) clr_req = 1'b0;
      if (cnt == 11) begin
        chk("mid_swept", rd_data1, 32'd0);
        chk("mid_unswept", rd_data2, model[20]);
      end
      if (clr_done) donePulses++;
      tick();
    end
    chk("busy_cycles", cnt, 32'd32);
    chk("done_pulse", {31'd0, clr_done}, 32'd1);
    chk("done_ready", {31'd0, wr_ready}, 32'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("done_len", {31'd0, clr_done}, 32'd0);
    tick();
    chk("req_in_done", {31'd0, clr_busy}, 32'd0);
    chk("req_in_done_dn", {31'd0, clr_done}, 32'd0);
    chk("done_in_sweep", donePulses, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      #1;
      checks++;
      assert (rd_data1 === 32'd0 && z0rd1 === 32'd0) else begin
        errors++;
        $error("FAIL cleared_r%0d: observed %h/%h expected 00000000", i, rd_data1, z0rd1);
      end
      model[i] = '0;
    end

    // Mid-sweep reset
    doWrite("r4_fill", 5'd4, 32'h44444444, 4'hF);
    doWrite("r30_fill", 5'd30, 32'h30303030, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("pre_rst_busy", {31'd0, clr_busy}, 32'd1);
    rd_addr1 = 5'd4; rd_addr2 = 5'd30;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, clr_busy}, 32'd0);
    chk("abort_ready", {31'd0, wr_ready}, 32'd1);
    chk("abort_r4", rd_data1, 32'd0);
    chk("abort_r30", rd_data2, 32'd0);
    #3 rst = 1'b0;
    donePulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_done || clr_busy) donePulses++;
      tick();
    end
    chk("abort_no_done", donePulses, 32'd0);

    // Write still works after abort
    doWrite("post_abort", 5'd12, 32'h0BADF00D, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register width in bits; it SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the address width; depth is DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set to 1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 wr_en  in  1  write request.
REQ-007 wr_addr  in  ADDR_W  write register index.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 wr_be  in  DATA_W/8  byte enables for the write.
REQ-010 wr_ready  out  1  write port accepting; a write is accepted when wr_en && wr_ready.
REQ-011 rd_addr1 / rd_addr2  in  ADDR_W  read indices, ports 1 and 2.
REQ-012 rd_data1 / rd_data2  out  DATA_W  read data, ports 1 and 2.
REQ-013 clr_req  in  1  single-cycle request to sweep-clear the whole file.
REQ-014 clr_busy  out  1  high while the clear sweep runs.
REQ-015 clr_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-016 Reads SHALL be combinational: rd_dataN = reg[rd_addrN], with zero latency.
REQ-017 With ZERO_REG=1, reads of index 0 SHALL return 0, and accepted writes to index 0 SHALL be discarded.
REQ-018 An accepted write SHALL update only the bytes with wr_be[i]=1 at the next rising edge; other bytes SHALL be kept.
REQ-019 A write with wr_be all zero SHALL leave the register unchanged.
REQ-020 The clear FSM SHALL have the states IDLE, SWEEP and DONE; it is reset to IDLE.
REQ-021 In IDLE, clr_req=1 SHALL move the FSM to SWEEP with sweep index idx=0.
REQ-022 In SWEEP, each cycle SHALL zero reg[idx] and increment idx; after clearing idx=DEPTH-1 the FSM SHALL move to DONE.
REQ-023 In DONE, the FSM SHALL assert clr_done for exactly one cycle and then return to IDLE.
REQ-024 clr_busy SHALL equal (state==SWEEP), and wr_ready SHALL equal !clr_busy.
REQ-025 From a clr_req sampled at edge 0, clr_busy SHALL be high for DEPTH cycles, and clr_done SHALL be high in the cycle after the last clear.
REQ-026 clr_req SHALL be ignored in SWEEP and in DONE.
REQ-027 If wr_en and clr_req are both high in IDLE, the write SHALL be accepted, and the sweep SHALL start at the next edge and clear that register.
REQ-028 During SWEEP, reads SHALL return the current contents: already-swept indices read 0, and unswept indices keep their values.
REQ-029 idx SHALL be ADDR_W bits wide and SHALL never wrap past DEPTH-1 within a sweep.

Reset
REQ-030 Asserting rst SHALL immediately zero all registers, set the FSM to IDLE, set idx to 0, and drive clr_busy=0, clr_done=0 and wr_ready=1, regardless of clk.
REQ-031 rst asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-032 With reset, rd_data1 and rd_data2 SHALL read 0 for every address.

Configuration
REQ-033 The macro REGFILE_BYPASS_EN, when defined, SHALL make a read port whose address equals an accepted same-cycle write address (and is not a ZERO_REG index 0) return the write data merged with the stored value per wr_be.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL return the stored value until the edge that commits the write.

Structure
REQ-035 A shared package regfile_pkg SHALL hold the clear-FSM state enum (IDLE, SWEEP, DONE) and the default DATA_W and ADDR_W constants.
REQ-036 One sub-module, regfile_clear_fsm, SHALL own the state, idx, clr_busy and clr_done; the array and the read and write logic stay in the top module.

Verification
REQ-037 Reset then write: rst pulse; write 0xDEADBEEF to r5 with be=4'hF -> rd_data1(addr 5) reads 0 before the edge and 0xDEADBEEF after it.
REQ-038 Byte enables: r7=0x11223344; write 0xAABBCCDD with be=4'b0101 -> r7 = 0x11BB33DD.
REQ-039 Zero register: write 0xFFFFFFFF to r0 -> r0 reads 0 (ZERO_REG=1); with ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
REQ-040 Clear sweep: fill r1..r31 with nonzero values; pulse clr_req -> clr_busy high 32 cycles, wr_ready low, clr_done pulses once, and all registers read 0.
REQ-041 Mid-sweep rst: assert rst at sweep cycle 10 -> clr_busy drops immediately, all registers read 0, and no clr_done pulse occurs.
REQ-042 Bypass: with REGFILE_BYPASS_EN, write 0x12345678 to r3 while rd_addr2=3 -> rd_data2 shows 0x12345678 in the same cycle; without the macro -> rd_data2 shows the old value.
